// File: rtl/calc_disp_pkg.sv
// rtl/calc_disp_pkg.sv - op codes, glyph codes, states and segment patterns for calc_result_display
package calc_disp_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } opCode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_ERR  = 2'd2
    } dispState_t;

    // Numeric glyph codes equal their digit value so a value maps directly to a code.
    localparam logic [3:0] GL_0     = 4'd0;
    localparam logic [3:0] GL_1     = 4'd1;
    localparam logic [3:0] GL_2     = 4'd2;
    localparam logic [3:0] GL_3     = 4'd3;
    localparam logic [3:0] GL_4     = 4'd4;
    localparam logic [3:0] GL_5     = 4'd5;
    localparam logic [3:0] GL_6     = 4'd6;
    localparam logic [3:0] GL_7     = 4'd7;
    localparam logic [3:0] GL_8     = 4'd8;
    localparam logic [3:0] GL_9     = 4'd9;
    localparam logic [3:0] GL_DASH  = 4'd10;
    localparam logic [3:0] GL_E     = 4'd11;
    localparam logic [3:0] GL_R     = 4'd12;
    localparam logic [3:0] GL_BLANK = 4'd13;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_glyph_rom.sv
// rtl/seg7_glyph_rom.sv - combinational glyph code to active-low 7-segment pattern
module seg7_glyph_rom
    import calc_disp_pkg::*;
(
    input  logic [3:0] glyph,
    output logic [6:0] segN
);

    always_comb begin
        segN = SEG_BLANK;
        case (glyph)
            GL_0:    segN = SEG_0;
            GL_1:    segN = SEG_1;
            GL_2:    segN = SEG_2;
            GL_3:    segN = SEG_3;
            GL_4:    segN = SEG_4;
            GL_5:    segN = SEG_5;
            GL_6:    segN = SEG_6;
            GL_7:    segN = SEG_7;
            GL_8:    segN = SEG_8;
            GL_9:    segN = SEG_9;
            GL_DASH: segN = SEG_DASH;
            GL_E:    segN = SEG_E;
            GL_R:    segN = SEG_R;
            default: segN = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_result_display.sv
// rtl/calc_result_display.sv - ALU result capture and 4-digit multiplexed display; BLINK_ERR_EN blinks the error pattern
module calc_result_display
    import calc_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int SCAN_W    = 16,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] res_in,
    input  logic       flag_in,
    input  logic [1:0] op_in,
    input  logic       cap_strobe,
    input  logic       clear,
    output logic [6:0] seg_n,
    output logic [3:0] an_n,
    output logic       err_out
);

    logic [SCAN_W-1:0] prescaler;
    logic [1:0]        idx;
    logic [1:0]        idxNext;
    logic              scanWrap;

    logic              capValid;
    logic [3:0]        capRes;
    logic              capFlag;
    opCode_t           capOp;

    dispState_t        state;
    dispState_t        stateNext;
    dispState_t        capState;
    logic [3:0][3:0]   glyphReg;
    logic [3:0][3:0]   glyphNext;
    logic [3:0][3:0]   capGlyph;
    logic [3:0]        mag;
    logic              isErr;

    logic [6:0]        segNext;
    logic [3:0]        anNext;
    logic              blankAll;

    // Scan prescaler and digit index
    assign scanWrap = (prescaler == SCAN_W'(SCAN_DIV - 1));
    assign idxNext  = scanWrap ? idx + 2'd1 : idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= 2'd0;
        end else begin
            prescaler <= scanWrap ? '0 : prescaler + SCAN_W'(1);
            idx       <= idxNext;
        end
    end

    // The capture stage holds the strobed bus; a same-cycle clear discards it.
    always_ff @(posedge clk) begin
        if (rst) begin
            capValid <= 1'b0;
            capRes   <= 4'd0;
            capFlag  <= 1'b0;
            capOp    <= OP_ADD;
        end else begin
            capValid <= cap_strobe && !clear;
            if (cap_strobe) begin
                capRes  <= res_in;
                capFlag <= flag_in;
                capOp   <= opCode_t'(op_in);
            end
        end
    end

    always_comb begin
        capGlyph = {GL_BLANK, GL_BLANK, GL_BLANK, GL_BLANK};
        capState = ST_SHOW;
        mag      = capRes;
        isErr    = 1'b0;
        case (capOp)
            OP_DIV: begin
                if (capFlag) begin
                    isErr = 1'b1;
                end else begin
                    capGlyph[2] = GL_0 + {2'b00, capRes[1:0]};
                    capGlyph[1] = GL_R;
                    capGlyph[0] = GL_0 + {2'b00, capRes[3:2]};
                end
            end
            OP_SUB: begin
                if (capRes[3]) begin
                    mag         = 4'(~capRes + 4'd1);
                    capGlyph[1] = GL_DASH;
                end
                capGlyph[0] = GL_0 + mag;
                isErr       = (mag > 4'd9);
            end
            default: begin
                capGlyph[0] = GL_0 + mag;
                isErr       = (mag > 4'd9);
            end
        endcase
        if (isErr) begin
            capGlyph = {GL_E, GL_R, GL_R, GL_BLANK};
            capState = ST_ERR;
        end
    end

    always_comb begin
        stateNext = state;
        glyphNext = glyphReg;
        if (clear) begin
            stateNext = ST_IDLE;
            glyphNext = {GL_DASH, GL_DASH, GL_DASH, GL_DASH};
        end else if (capValid) begin
            stateNext = capState;
            glyphNext = capGlyph;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            glyphReg <= {GL_DASH, GL_DASH, GL_DASH, GL_DASH};
            err_out  <= 1'b0;
        end else begin
            state    <= stateNext;
            glyphReg <= glyphNext;
            err_out  <= (stateNext == ST_ERR);
        end
    end

`ifdef BLINK_ERR_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] blinkCnt;
    logic [BLINK_W-1:0] blinkCntNext;
    logic               phase;
    logic               phaseNext;

    // Entering ERR restarts the blink so the error pattern first appears lit.
    always_comb begin
        blinkCntNext = blinkCnt;
        phaseNext    = phase;
        if (stateNext == ST_ERR && state != ST_ERR) begin
            blinkCntNext = '0;
            phaseNext    = 1'b0;
        end else if (scanWrap) begin
            if (blinkCnt == BLINK_W'(BLINK_DIV - 1)) begin
                blinkCntNext = '0;
                phaseNext    = ~phase;
            end else begin
                blinkCntNext = blinkCnt + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blinkCnt <= '0;
            phase    <= 1'b0;
        end else begin
            blinkCnt <= blinkCntNext;
            phase    <= phaseNext;
        end
    end

    assign blankAll = (stateNext == ST_ERR) && phaseNext;
`else
    logic unusedBlinkDiv;
    assign unusedBlinkDiv = ^BLINK_DIV;
    assign blankAll       = 1'b0;
`endif

    // Segments and anodes both look up the next index so they switch together.
    seg7_glyph_rom u_rom (
        .glyph (glyphReg[idxNext]),
        .segN  (segNext)
    );

    assign anNext = blankAll ? 4'hF : ~(4'b0001 << idxNext);

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_n <= SEG_BLANK;
            an_n  <= 4'hF;
        end else begin
            seg_n <= segNext;
            an_n  <= anNext;
        end
    end

endmodule

// File: tb/tb_calc_result_display.sv
// tb/tb_calc_result_display.sv - directed vector bench for calc_result_display
module tb_calc_result_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;
`ifdef BLINK_ERR_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] res_in;
    logic       flag_in;
    logic [1:0] op_in;
    logic       cap_strobe;
    logic       clear;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic       err_out;

    int checks = 0;
    int fails  = 0;
    int modelPre;
    int modelIdx;

    localparam logic [27:0] DASHES  = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
    localparam logic [27:0] ERR_PAT = {7'h06, 7'h2F, 7'h2F, 7'h7F};

    typedef struct {
        logic [1:0]      op;
        logic [3:0]      res;
        logic            flag;
        logic [3:0][6:0] seg;
        logic            err;
    } vec_t;

    vec_t vecs [15];

    calc_result_display #(
        .SCAN_DIV  (SCAN_DIV),
        .SCAN_W    (4),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .res_in     (res_in),
        .flag_in    (flag_in),
        .op_in      (op_in),
        .cap_strobe (cap_strobe),
        .clear      (clear),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .err_out    (err_out)
    );

    always #5 clk = ~clk;

    // Reference scan position, independent of anything captured.
    always @(posedge clk) begin
        if (rst) begin
            modelPre <= 0;
            modelIdx <= 0;
        end else if (modelPre == SCAN_DIV - 1) begin
            modelPre <= 0;
            modelIdx <= (modelIdx + 1) % 4;
        end else begin
            modelPre <= modelPre + 1;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic checkDisplay(input logic [3:0][6:0] expSeg, input logic expErr,
                                input int cycles, input string name);
        int blanks = 0;
        for (int c = 0; c < cycles; c++) begin
            logic [3:0] expAn;
            logic       ok;
            expAn = ~(4'b0001 << modelIdx);
            ok    = (err_out === expErr);
            checks++;
            if (BLINK && expErr && an_n === 4'hF) begin
                blanks++;
            end else begin
                ok = ok && (an_n === expAn) && (seg_n === expSeg[modelIdx]);
            end
            if (!ok) begin
                fails++;
                $display("FAIL %s cycle %0d: an_n=%b seg_n=%h err_out=%b, required an_n=%b seg_n=%h err_out=%b",
                         name, c, an_n, seg_n, err_out, expAn, expSeg[modelIdx], expErr);
            end
            @(negedge clk);
        end
`ifdef BLINK_ERR_EN
        checks++;
        if (expErr ? (blanks == 0) : (blanks != 0)) begin
            fails++;
            $display("FAIL %s blink: blanked cycles %0d, required %s", name, blanks,
                     expErr ? "some" : "none");
        end
`endif
    endtask

    // Called at a falling edge; returns at the falling edge after the new glyphs reach seg_n.
    task automatic strobe(input logic [1:0] op, input logic [3:0] res, input logic flag, input logic clr);
        op_in      = op;
        res_in     = res;
        flag_in    = flag;
        cap_strobe = 1'b1;
        clear      = clr;
        @(negedge clk);
        cap_strobe = 1'b0;
        clear      = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b00, 4'b0100, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h19}, 1'b0};
        vecs[1]  = '{2'b01, 4'b1110, 1'b0, {7'h7F, 7'h7F, 7'h3F, 7'h24}, 1'b0};
        vecs[2]  = '{2'b11, 4'b0101, 1'b0, {7'h7F, 7'h79, 7'h2F, 7'h79}, 1'b0};
        vecs[3]  = '{2'b11, 4'b0000, 1'b1, ERR_PAT, 1'b1};
        vecs[4]  = '{2'b10, 4'b1111, 1'b0, ERR_PAT, 1'b1};
        vecs[5]  = '{2'b00, 4'b1001, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h10}, 1'b0};
        vecs[6]  = '{2'b01, 4'b0111, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 1'b0};
        vecs[7]  = '{2'b01, 4'b1000, 1'b0, {7'h7F, 7'h7F, 7'h3F, 7'h00}, 1'b0};
        vecs[8]  = '{2'b00, 4'b1010, 1'b0, ERR_PAT, 1'b1};
        vecs[9]  = '{2'b11, 4'b1110, 1'b0, {7'h7F, 7'h24, 7'h2F, 7'h30}, 1'b0};
        vecs[10] = '{2'b10, 4'b0110, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h02}, 1'b0};
        vecs[11] = '{2'b00, 4'b0101, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 1'b0};
        vecs[12] = '{2'b01, 4'b0011, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h30}, 1'b0};
        vecs[13] = '{2'b00, 4'b0000, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0};
        vecs[14] = '{2'b10, 4'b1000, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h00}, 1'b0};

        rst        = 1'b1;
        res_in     = 4'd0;
        flag_in    = 1'b0;
        op_in      = 2'b00;
        cap_strobe = 1'b0;
        clear      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset seg_n", 16'(seg_n), 16'h7F);
        check("reset an_n", 16'(an_n), 16'hF);
        check("reset err_out", 16'(err_out), 16'h0);

        rst = 1'b0;
        @(negedge clk);
        checkDisplay(DASHES, 1'b0, 20, "idle scan");

        for (int i = 0; i < 15; i++) begin
            strobe(vecs[i].op, vecs[i].res, vecs[i].flag, 1'b0);
            checkDisplay(vecs[i].seg, vecs[i].err, 16, $sformatf("vec%0d", i));
        end

        // err_out follows the state change exactly one edge after the strobe edge
        op_in      = 2'b11;
        res_in     = 4'b0000;
        flag_in    = 1'b1;
        cap_strobe = 1'b1;
        @(negedge clk);
        cap_strobe = 1'b0;
        check("err_out before update", 16'(err_out), 16'h0);
        @(negedge clk);
        check("err_out on update", 16'(err_out), 16'h1);
        @(negedge clk);
        checkDisplay(ERR_PAT, 1'b1, 16, "div by zero");

        strobe(2'b00, 4'b0011, 1'b0, 1'b1);
        checkDisplay(DASHES, 1'b0, 16, "clear beats strobe");

        strobe(2'b10, 4'b1111, 1'b0, 1'b0);
        checkDisplay(ERR_PAT, 1'b1, 16, "mul overflow");

        // reset with a capture in flight
        op_in      = 2'b00;
        res_in     = 4'b0111;
        flag_in    = 1'b0;
        cap_strobe = 1'b1;
        @(negedge clk);
        cap_strobe = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        check("midscan rst seg_n", 16'(seg_n), 16'h7F);
        check("midscan rst an_n", 16'(an_n), 16'hF);
        check("midscan rst err_out", 16'(err_out), 16'h0);
        rst = 1'b0;
        @(negedge clk);
        checkDisplay(DASHES, 1'b0, 16, "after reset");

        // back-to-back strobes: the later one is displayed
        op_in      = 2'b00;
        res_in     = 4'b0001;
        cap_strobe = 1'b1;
        @(negedge clk);
        res_in = 4'b0010;
        @(negedge clk);
        cap_strobe = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkDisplay({7'h7F, 7'h7F, 7'h7F, 7'h24}, 1'b0, 16, "last strobe wins");

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        checkDisplay(DASHES, 1'b0, 16, "clear alone");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/calc_result_display.md
Name: calc_result_display

Overview:
- Consumer side of the 2-bit ALU result bus.
- Captures the ALU's 4-bit result, its flag and the op code when strobed, and interprets the value per operation (unsigned, signed two's complement, or remainder/quotient).
- Renders the value on a time-multiplexed 4-digit 7-segment display. Shows an error pattern on divide-by-zero or an undisplayable value.
- Sits between the ALU top and the board's segment/anode pins.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot; minimum 2.
- SCAN_W, 16, prescaler counter width; must satisfy 2^SCAN_W >= SCAN_DIV.
- BLINK_DIV, 64, number of scan wraps per blink half-period; used only with BLINK_ERR_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- res_in  input  4  ALU result bus.
- flag_in  input  1  ALU flag: carry, borrow, overflow or divide-by-zero.
- op_in  input  2  ALU op: 00 add, 01 sub, 10 mul, 11 div.
- cap_strobe  input  1  one-cycle capture request.
- clear  input  1  return the display to idle.
- seg_n  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- an_n  output  4  active-low digit enables; bit 0 is the rightmost digit.
- err_out  output  1  high while in the ERR state.

Behaviour:
- Reset: state IDLE; seg_n=7'h7F; an_n=4'hF; err_out=0; prescaler=0; digit index=0; glyph registers set to "----".
- Scan timing:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On each wrap the digit index advances 0→1→2→3→0.
  - From the first cycle after reset, an_n is driven registered with one low bit, equal to ~(1<<idx).
  - seg_n is registered; it always matches the glyph of the currently enabled digit, with no one-cycle skew between an_n and seg_n.
- Capture:
  - When cap_strobe=1 at edge N, res_in, flag_in and op_in are registered.
  - The glyph registers and state update at edge N+1.
  - seg_n/an_n reflect the new glyphs from edge N+2.
  - The scan position is not disturbed by a capture.
- Interpretation (glyph order is digit3..digit0; "_" = blank):
  - ADD: value = res_in unsigned; shown as "___v".
  - SUB: if res_in[3]=1, show "__-m" with m = two's-complement magnitude; otherwise "___v".
  - MUL: value = res_in unsigned; shown as "___v".
  - DIV with flag=0: q = res_in[1:0], r = res_in[3:2]; shown as "_qrR", where "r" is the literal glyph r and R is the remainder digit.
  - DIV with flag=1: "Err_"; state goes to ERR.
  - Any magnitude > 9: "Err_"; state goes to ERR.
- FSM states: IDLE, SHOW, ERR.
  - Any state + cap_strobe → SHOW or ERR, according to the interpretation above.
  - Any state + clear → IDLE (glyphs "----").
  - clear and cap_strobe in the same cycle: clear wins and the capture is discarded.
  - Repeated strobes are each processed; the last one wins.
- err_out is asserted in ERR only, registered, in the same cycle the state changes.
- rst asserted mid-scan or mid-capture forces the full reset values on the next edge.
- Glyph set: 0-9, '-', 'E', 'r', blank. Any unknown glyph code renders as blank.

Optional Feature:
- Macro: BLINK_ERR_EN.
- Defined:
  - A blink counter counts scan wraps and toggles a phase flag every BLINK_DIV wraps.
  - In ERR with phase=1, an_n is forced to 4'hF; err_out stays high.
  - The counter and phase are cleared on reset and on entry to ERR, so ERR entry starts visible.
- Undefined: the ERR pattern displays steadily; no blink counter exists.

Decomposition:
- Package calc_disp_pkg holds:
  - op code constants OP_ADD/OP_SUB/OP_MUL/OP_DIV.
  - 4-bit glyph codes GL_0..GL_9, GL_DASH, GL_E, GL_R, GL_BLANK.
  - state encoding ST_IDLE/ST_SHOW/ST_ERR.
  - the segment pattern constants.
- One sub-module, seg7_glyph_rom: combinational, glyph code → 7-bit active-low segments.

Test Plan (SCAN_DIV=4, BLINK_DIV=2):
- Reset then run 20 cycles → an_n steps 1110, 1101, 1011, 0111 every 4 cycles; seg_n=7'h3F on every digit (dash); err_out=0.
- Strobe op=00, res=0100 → after 2 cycles digit0 shows 7'h19 ('4'); digits 1-3 show 7'h7F; state SHOW.
- Strobe op=01, res=1110 → digit1 shows '-' (7'h3F), digit0 shows '2' (7'h24).
- Strobe op=11, res=0101, flag=0 → digit2='1' (7'h79), digit1='r' (7'h2F), digit0='1'; err_out=0.
- Strobe op=11, flag=1 → "Err_"; err_out=1 on the next edge. With BLINK_ERR_EN, an_n=1111 during alternate 8-cycle windows.
- Strobe and clear in the same cycle while in ERR, then op=10, res=1111 → first: IDLE with "----", err_out=0. Second: ERR (value 15 > 9). Then rst mid-scan → seg_n=7'h7F, an_n=4'hF next edge.
